shift_arbiter: RTL and testbench

Two-port arbiter that shares the single shift/rotation unit between two requesters: requester 0 is the execute-stage operand-2 shifter and requester 1 is the load/store address scaler. It accepts requests over valid/ready, registers the granted operands, and drives them to the shared unit for one cycle. It captures the unit's result into a per-requester response slot, which it holds under backpressure.

---
 rtl/shift_arbiter.sv | 115 +++++++++++
 tb/tb_shift_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift/rotate unit between two requesters.
// Each requester owns a response slot (EMPTY/PENDING/FULL) that holds its result until consumed.
module shift_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_rottype,
  input  logic [1:0]   req0_shiftfun,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [W-1:0] rsp0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_rottype,
  input  logic [1:0]   req1_shiftfun,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp1_data,
  output logic [W-1:0] su_a,
  output logic [W-1:0] su_b,
  output logic         su_rottype,
  output logic [1:0]   su_shiftfun,
  input  logic [W-1:0] su_s
);

  typedef enum logic [1:0] {S_EMPTY, S_PEND, S_FULL} slot_e;

  slot_e              slot_q [2];
  slot_e              slot_d [2];
  logic               ptr_q, ptr_d;
  logic               iss_vld_q;
  logic               iss_own_q;
  logic [W-1:0]       iss_a_q, iss_b_q;
  logic               iss_rt_q;
  logic [1:0]         iss_fn_q;
  logic [1:0][W-1:0]  rsp_data_q;

  logic [1:0] req_valid, rsp_ready, elig, cand, ready, grant;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  always_comb begin
    elig = '0;
    for (int n = 0; n < 2; n++)
      elig[n] = (slot_q[n] == S_EMPTY) || ((slot_q[n] == S_FULL) && rsp_ready[n]);
  end

  // ptr_q names the last winner; on contention the other requester goes.
  assign cand     = req_valid & elig;
  assign ready[0] = !rst && elig[0] && (!cand[1] || ptr_q);
  assign ready[1] = !rst && elig[1] && (!cand[0] || !ptr_q);
  assign grant    = req_valid & ready;

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];

  always_comb begin
    ptr_d = grant[1] ? 1'b1 : (grant[0] ? 1'b0 : ptr_q);
    for (int n = 0; n < 2; n++) begin
      slot_d[n] = slot_q[n];
      case (slot_q[n])
        S_EMPTY: if (grant[n]) slot_d[n] = S_PEND;
        S_PEND:  slot_d[n] = S_FULL;
        S_FULL:  if (rsp_ready[n]) slot_d[n] = grant[n] ? S_PEND : S_EMPTY;
        default: slot_d[n] = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 2; n++) slot_q[n] <= S_EMPTY;
      ptr_q      <= 1'b1;
      iss_vld_q  <= 1'b0;
      iss_own_q  <= 1'b0;
      iss_a_q    <= '0;
      iss_b_q    <= '0;
      iss_rt_q   <= 1'b0;
      iss_fn_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      for (int n = 0; n < 2; n++) slot_q[n] <= slot_d[n];
      ptr_q     <= ptr_d;
      iss_vld_q <= |grant;
      if (|grant) begin
        iss_own_q <= grant[1];
        iss_a_q   <= grant[1] ? req1_a        : req0_a;
        iss_b_q   <= grant[1] ? req1_b        : req0_b;
        iss_rt_q  <= grant[1] ? req1_rottype  : req0_rottype;
        iss_fn_q  <= grant[1] ? req1_shiftfun : req0_shiftfun;
      end
      // Unit result is only meaningful at the edge closing the issue cycle.
      if (iss_vld_q) rsp_data_q[iss_own_q] <= su_s;
    end
  end

  assign su_a        = iss_vld_q ? iss_a_q  : '0;
  assign su_b        = iss_vld_q ? iss_b_q  : '0;
  assign su_rottype  = iss_vld_q ? iss_rt_q : 1'b0;
  assign su_shiftfun = iss_vld_q ? iss_fn_q : 2'b00;

  assign rsp0_valid = (slot_q[0] == S_FULL);
  assign rsp1_valid = (slot_q[1] == S_FULL);
  assign rsp0_data  = rsp_data_q[0];
  assign rsp1_data  = rsp_data_q[1];

endmodule

// File: tb/tb_shift_arbiter.sv
// Random and directed stimulus for shift_arbiter against an age-based slot model;
// the bench also plays the shared shift unit.
module tb_shift_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        v [2];
  logic        rr [2];
  logic [31:0] ra [2];
  logic [31:0] rb [2];
  logic        rt [2];
  logic [1:0]  rf [2];
  logic        rdy0, rdy1, rv0, rv1;
  logic [31:0] rd0, rd1, su_a, su_b, su_s;
  logic        su_rt;
  logic [1:0]  su_fn;

  int nvec = 0, nerr = 0;

  // model: per requester an outstanding result and its age in edges since grant
  bit          m_pres [2];
  int          m_age  [2];
  logic [31:0] m_data [2];
  int          m_last;
  bit          m_iv;
  logic [31:0] m_ia;
  logic [1:0]  m_ifn;

  always #5 clk = ~clk;

  shift_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(v[0]), .req0_ready(rdy0), .req0_a(ra[0]), .req0_b(rb[0]),
    .req0_rottype(rt[0]), .req0_shiftfun(rf[0]),
    .rsp0_valid(rv0), .rsp0_ready(rr[0]), .rsp0_data(rd0),
    .req1_valid(v[1]), .req1_ready(rdy1), .req1_a(ra[1]), .req1_b(rb[1]),
    .req1_rottype(rt[1]), .req1_shiftfun(rf[1]),
    .rsp1_valid(rv1), .rsp1_ready(rr[1]), .rsp1_data(rd1),
    .su_a(su_a), .su_b(su_b), .su_rottype(su_rt), .su_shiftfun(su_fn), .su_s(su_s)
  );

  // rottype selects rotate-left for the rotate function
  function automatic logic [31:0] shf(logic [31:0] a, logic [31:0] b, logic r, logic [1:0] fn);
    int amt;
    amt = int'(b[4:0]);
    case (fn)
      2'd0:    return a << amt;
      2'd1:    return a >> amt;
      2'd2:    return 32'($signed(a) >>> amt);
      default: return r ? ((a << amt) | (a >> (32 - amt))) : ((a >> amt) | (a << (32 - amt)));
    endcase
  endfunction

  assign su_s = shf(su_a, su_b, su_rt, su_fn);

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    m_pres = '{0, 0}; m_age = '{0, 0}; m_data = '{0, 0};
    m_last = 1; m_iv = 0; m_ia = '0; m_ifn = '0;
  endtask

  function automatic bit elig(int n);
    return !m_pres[n] || (m_age[n] >= 1 && rr[n]);
  endfunction

  function automatic bit exp_rdy(int n);
    bit other;
    other = v[1-n] && elig(1-n);
    return !rst && elig(n) && (!other || m_last != n);
  endfunction

  // one clock: check all outputs mid-cycle, then advance model at the edge
  task automatic tick();
    bit g [2];
    @(negedge clk);
    chk("rdy0", 32'(rdy0), 32'(exp_rdy(0)));
    chk("rdy1", 32'(rdy1), 32'(exp_rdy(1)));
    chk("rvld0", 32'(rv0), 32'(m_pres[0] && m_age[0] >= 1));
    chk("rvld1", 32'(rv1), 32'(m_pres[1] && m_age[1] >= 1));
    if (m_pres[0] && m_age[0] >= 1) chk("rdat0", rd0, m_data[0]);
    if (m_pres[1] && m_age[1] >= 1) chk("rdat1", rd1, m_data[1]);
    chk("su_a", su_a, m_iv ? m_ia : 32'h0);
    chk("su_fn", 32'(su_fn), 32'(m_iv ? m_ifn : 2'b00));
    for (int n = 0; n < 2; n++) g[n] = v[n] && exp_rdy(n);
    @(posedge clk);
    if (rst) mreset();
    else begin
      m_iv = 0;
      for (int n = 0; n < 2; n++) begin
        if (m_pres[n] && m_age[n] >= 1 && rr[n]) m_pres[n] = 0;
        if (m_pres[n]) m_age[n]++;
        if (g[n]) begin
          m_pres[n] = 1; m_age[n] = 0;
          m_data[n] = shf(ra[n], rb[n], rt[n], rf[n]);
          m_last = n; m_iv = 1; m_ia = ra[n]; m_ifn = rf[n];
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    v = '{0, 0}; rr = '{1, 1};
  endtask

  task automatic do_reset();
    rst = 1; idle(); tick(); tick(); rst = 0;
  endtask

  task automatic setreq(int n, logic [31:0] a, logic [31:0] b, logic r, logic [1:0] fn);
    v[n] = 1; ra[n] = a; rb[n] = b; rt[n] = r; rf[n] = fn;
  endtask

  initial begin
    logic [31:0] held;
    int exp_alt;
    rst = 1; idle();
    ra = '{0, 0}; rb = '{0, 0}; rt = '{0, 0}; rf = '{0, 0};
    mreset();
    @(posedge clk); #1;
    do_reset();

    // reset state and single LSL
    chk("rst_rv0", 32'(rv0), 0); chk("rst_rv1", 32'(rv1), 0);
    chk("rst_rd0", rd0, 0); chk("rst_rd1", rd1, 0); chk("rst_su_a", su_a, 0);
    setreq(0, 32'h1, 32'd4, 0, 2'b00); #1;
    chk("rst_rdy0", 32'(rdy0), 1);
    tick(); v[0] = 0;
    chk("lsl_su_a", su_a, 32'h1); chk("lsl_su_fn", 32'(su_fn), 0);
    tick();
    chk("lsl_rv0", 32'(rv0), 1); chk("lsl_rd0", rd0, 32'h10);
    tick(); tick();

    // contention right after reset
    do_reset();
    setreq(0, 32'h8000_0000, 32'd4, 0, 2'b10);
    setreq(1, 32'h1, 32'd1, 0, 2'b11); #1;
    chk("cont_rdy0", 32'(rdy0), 1); chk("cont_rdy1", 32'(rdy1), 0);
    tick(); v[0] = 0; #1;
    chk("cont_rdy1b", 32'(rdy1), 1);
    tick(); v[1] = 0;
    chk("cont_rd0", rd0, 32'hF800_0000);
    tick();
    chk("cont_rd1", rd1, 32'h8000_0000);
    tick(); tick();

    // backpressure on requester 0
    do_reset();
    setreq(0, 32'h3, 32'd2, 0, 2'b00); rr[0] = 0;
    tick(); v[0] = 0; tick();
    held = rd0;
    chk("bp_full", 32'(rv0), 1);
    setreq(0, 32'h5, 32'd1, 0, 2'b01); setreq(1, 32'hF0, 32'd4, 0, 2'b01);
    for (int i = 0; i < 5; i++) begin
      #1; chk("bp_rdy0", 32'(rdy0), 0); chk("bp_hold", rd0, held);
      tick();
    end
    rr[0] = 1; #1;
    chk("bp_drain_rdy0", 32'(rdy0), 1);
    tick(); idle(); tick(); tick(); tick();

    // reset in the cycle after a grant
    do_reset();
    setreq(0, 32'h7, 32'd1, 0, 2'b00);
    tick(); v[0] = 0; rst = 1;
    tick(); rst = 0;
    chk("mid_rv0", 32'(rv0), 0);
    v[0] = 1; #1;
    chk("mid_rdy0", 32'(rdy0), 1);
    tick(); idle(); tick(); tick();

    // streaming
    do_reset();
    exp_alt = 0;
    for (int i = 0; i < 20; i++) begin
      setreq(0, $urandom, $urandom, 1'($urandom), 2'($urandom));
      setreq(1, $urandom, $urandom, 1'($urandom), 2'($urandom)); #1;
      chk("str_one", 32'(rdy0) + 32'(rdy1), 1);
      chk("str_alt", rdy1 ? 1 : 0, 32'(exp_alt));
      exp_alt = 1 - exp_alt;
      tick();
    end
    idle(); tick(); tick(); tick();

    // random
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int n = 0; n < 2; n++) begin
        v[n]  = 1'($urandom);
        rr[n] = ($urandom_range(0, 9) < 7);
        ra[n] = $urandom; rb[n] = $urandom;
        rt[n] = 1'($urandom); rf[n] = 2'($urandom);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
